// File: rtl/sd_pkg.sv
// Shared constants, state encodings and command-byte helper for the SD block reader.
`timescale 1ns/1ps
package sd_pkg;

   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned CNT_W       = 9;
   localparam int unsigned RETRY_W     = 12;
   localparam int unsigned ADDR_W      = 16;
   localparam int unsigned BLOCK_BYTES = 512;
   localparam int unsigned CRC_BYTES   = 2;
   localparam int unsigned CMD_BYTES   = 6;

   localparam logic [1:0] SPI_XCHG    = 2'd0;
   localparam logic [1:0] SPI_CS_LOW  = 2'd1;
   localparam logic [1:0] SPI_CS_HIGH = 2'd2;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_R1    = 2'd1;
   localparam logic [1:0] ERR_TOKEN = 2'd2;
   localparam logic [1:0] ERR_SPI   = 2'd3;

   localparam logic [7:0] CMD17      = 8'h51;
   localparam logic [7:0] DATA_TOKEN = 8'hFE;
   localparam logic [7:0] IDLE_BYTE  = 8'hFF;

   typedef enum logic [3:0] {
      IDLE, CS_LO, CMD, R1, TOKEN, DATA, CRC, CS_HI, FIN
   } rd_state_e;

   typedef enum logic [1:0] {
      X_IDLE, X_SENT, X_SKIP, X_WAIT
   } xf_state_e;

   // Byte idx of the CMD17 frame: opcode, 32-bit address MSB first, dummy CRC.
   function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] addr);
      logic [7:0] b;
      case (idx)
         3'd0:    b = CMD17;
         3'd1:    b = addr[31:24];
         3'd2:    b = addr[23:16];
         3'd3:    b = addr[15:8];
         3'd4:    b = addr[7:0];
         default: b = IDLE_BYTE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sd_xfer_byte.sv
// One SPI operation: strobe the command, skip a cycle, then wait for the SPI engine to go idle.
`timescale 1ns/1ps
module sd_xfer_byte
   import sd_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       go_i,
   input  logic [1:0] cmd_i,
   input  logic [7:0] byte_i,
   input  logic [1:0] spi_st_i,
   output logic       spi_sent_o,
   output logic [1:0] spi_cmd_o,
   output logic [7:0] spi_out_o,
   output logic       ack_c,
   output logic       tmo_c
);

   xf_state_e  state_q;
   logic       spi_sent_q;
   logic [1:0] spi_cmd_q;
   logic [7:0] spi_out_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= X_IDLE;
         spi_sent_q <= 1'b0;
         spi_cmd_q  <= SPI_XCHG;
         spi_out_q  <= IDLE_BYTE;
      end else begin
         spi_sent_q <= 1'b0;
         case (state_q)
            X_IDLE: if (go_i) begin
               spi_sent_q <= 1'b1;
               spi_cmd_q  <= cmd_i;
               spi_out_q  <= byte_i;
               state_q    <= X_SENT;
            end
            X_SENT:  state_q <= X_SKIP;
            // the engine's busy flag is not trustworthy until a cycle after the strobe
            X_SKIP:  state_q <= X_WAIT;
            X_WAIT:  if (!spi_st_i[0]) state_q <= X_IDLE;
            default: state_q <= X_IDLE;
         endcase
      end
   end

   assign ack_c      = (state_q == X_WAIT) && !spi_st_i[0];
   assign tmo_c      = ack_c && spi_st_i[1];
   assign spi_sent_o = spi_sent_q;
   assign spi_cmd_o  = spi_cmd_q;
   assign spi_out_o  = spi_out_q;

endmodule

// File: rtl/sd_block_reader.sv
// Reads one 512-byte SD sector over SPI (CMD17) and streams it into RAM at a given base.
`timescale 1ns/1ps
module sd_block_reader
   import sd_pkg::*;
#(
   parameter int unsigned SDHC        = 1,
   parameter int unsigned R1_TRIES    = 16,
   parameter int unsigned TOKEN_TRIES = 4096
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] lba,
   input  logic [15:0] dest,
   output logic        busy,
   output logic        done,
   output logic [1:0]  error,
   output logic        spi_sent,
   output logic [1:0]  spi_cmd,
   output logic [7:0]  spi_out,
   input  logic [7:0]  spi_din,
   input  logic [1:0]  spi_st,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_data,
   output logic        ram_we
);

   rd_state_e          state_q;
   logic [31:0]        addr_q;
   logic [ADDR_W-1:0]  dest_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [RETRY_W-1:0] retry_q;
   logic               pend_q;
   logic               go_q;
   logic [1:0]         xcmd_q;
   logic [7:0]         xbyte_q;
   logic               busy_q;
   logic               done_q;
   logic [1:0]         error_q;
   logic [ADDR_W-1:0]  ram_addr_q;
   logic [7:0]         ram_data_q;
   logic               ram_we_q;

   logic [31:0]        addr_d;
   logic [1:0]         op_cmd;
   logic [7:0]         op_byte;
   logic               ack_c;
   logic               tmo_c;

   // Standard-capacity cards take a byte address rather than a block number.
   assign addr_d = (SDHC != 0) ? lba : {lba[22:0], 9'd0};

   always_comb begin
      op_cmd  = SPI_XCHG;
      op_byte = IDLE_BYTE;
      case (state_q)
         CS_LO:   op_cmd  = SPI_CS_LOW;
         CMD:     op_byte = cmd_byte(cnt_q[2:0], addr_q);
         CS_HI:   op_cmd  = SPI_CS_HIGH;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         dest_q     <= '0;
         cnt_q      <= '0;
         retry_q    <= '0;
         pend_q     <= 1'b0;
         go_q       <= 1'b0;
         xcmd_q     <= SPI_XCHG;
         xbyte_q    <= IDLE_BYTE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= ERR_NONE;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         ram_we_q   <= 1'b0;
      end else begin
         go_q     <= 1'b0;
         done_q   <= 1'b0;
         ram_we_q <= 1'b0;
         if (state_q == IDLE) begin
            if (start) begin
               addr_q  <= addr_d;
               dest_q  <= dest;
               error_q <= ERR_NONE;
               busy_q  <= 1'b1;
               cnt_q   <= '0;
               retry_q <= '0;
               pend_q  <= 1'b0;
               state_q <= CS_LO;
            end
         end else if (state_q == FIN) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
         end else if (!pend_q) begin
            go_q    <= 1'b1;
            xcmd_q  <= op_cmd;
            xbyte_q <= op_byte;
            pend_q  <= 1'b1;
         end else if (ack_c) begin
            pend_q <= 1'b0;
            if (tmo_c) begin
               // a timeout while releasing CS must not loop back into CS_HI
               error_q <= ERR_SPI;
               state_q <= (state_q == CS_HI) ? FIN : CS_HI;
            end else begin
               case (state_q)
                  CS_LO: begin
                     cnt_q   <= '0;
                     state_q <= CMD;
                  end
                  CMD: begin
                     if (cnt_q == CNT_W'(CMD_BYTES - 1)) begin
                        cnt_q   <= '0;
                        retry_q <= '0;
                        state_q <= R1;
                     end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end
                  R1: begin
                     if (spi_din == 8'h00) begin
                        retry_q <= '0;
                        state_q <= TOKEN;
                     end else if (spi_din == IDLE_BYTE && retry_q != RETRY_W'(R1_TRIES - 1)) begin
                        retry_q <= retry_q + RETRY_W'(1);
                     end else begin
                        error_q <= ERR_R1;
                        state_q <= CS_HI;
                     end
                  end
                  TOKEN: begin
                     if (spi_din == DATA_TOKEN) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                     end else if (spi_din == IDLE_BYTE && retry_q != RETRY_W'(TOKEN_TRIES - 1)) begin
                        retry_q <= retry_q + RETRY_W'(1);
                     end else begin
                        error_q <= ERR_TOKEN;
                        state_q <= CS_HI;
                     end
                  end
                  DATA: begin
                     ram_we_q   <= 1'b1;
                     ram_addr_q <= dest_q + ADDR_W'(cnt_q);
                     ram_data_q <= spi_din;
                     if (cnt_q == CNT_W'(BLOCK_BYTES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= CRC;
                     end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end
                  CRC: begin
                     if (cnt_q == CNT_W'(CRC_BYTES - 1)) state_q <= CS_HI;
                     else cnt_q <= cnt_q + CNT_W'(1);
                  end
                  CS_HI:   state_q <= FIN;
                  default: state_q <= IDLE;
               endcase
            end
         end
      end
   end

   sd_xfer_byte u_xfer (
      .clock      (clock),
      .reset      (reset),
      .go_i       (go_q),
      .cmd_i      (xcmd_q),
      .byte_i     (xbyte_q),
      .spi_st_i   (spi_st),
      .spi_sent_o (spi_sent),
      .spi_cmd_o  (spi_cmd),
      .spi_out_o  (spi_out),
      .ack_c      (ack_c),
      .tmo_c      (tmo_c)
   );

   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign ram_addr = ram_addr_q;
   assign ram_data = ram_data_q;
   assign ram_we   = ram_we_q;

endmodule

// File: doc/sd_block_reader.md
SD_BLOCK_READER -- requirements
Module: sd_block_reader

Interface
REQ-001 SHALL have parameter SDHC, default 1: 1 = lba sent as block address; 0 = lba shifted left 9 (byte address).
REQ-002 SHALL have parameter R1_TRIES, default 16: max polls for the R1 response.
REQ-003 SHALL have parameter TOKEN_TRIES, default 4096: max polls for the 0xFE data token.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clock, input, 1: 25 MHz system clock.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port start, input, 1: one-cycle request, sampled only in IDLE.
REQ-008 SHALL have port lba, input, 32: sector number, latched on start.
REQ-009 SHALL have port dest, input, 16: RAM base address, latched on start.
REQ-010 SHALL have port busy, output, 1: high from the cycle after start until DONE/ERR.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at completion.
REQ-012 SHALL have port error, output, 2: 0 ok, 1 R1 timeout or nonzero R1, 2 token timeout or error token, 3 SPI timeout.
REQ-013 SHALL have port spi_sent, output, 1: one-cycle command strobe.
REQ-014 SHALL have port spi_cmd, output, 2: 0 exchange byte, 1 CS low, 2 CS high.
REQ-015 SHALL have port spi_out, output, 8: byte to transmit.
REQ-016 SHALL have port spi_din, input, 8: received byte.
REQ-017 SHALL have port spi_st, input, 2: bit0 busy, bit1 timeout.
REQ-018 SHALL have port ram_addr, output, 16: write address.
REQ-019 SHALL have port ram_data, output, 8: write data.
REQ-020 SHALL have port ram_we, output, 1: one-cycle write strobe.

Function
REQ-021 SHALL use states IDLE, CS_LO, CMD, R1, TOKEN, DATA, CRC, CS_HI, FIN.
REQ-022 SHALL perform every SPI operation as: strobe spi_sent one cycle; skip one cycle; wait until spi_st[0]=0; then spi_din is valid.
REQ-023 SHALL go IDLE->CS_LO on start, latching lba/dest and clearing error; start outside IDLE SHALL be ignored.
REQ-024 SHALL, in CMD, send 6 bytes: 0x51, address[31:24..7:0] MSB first, 0xFF.
REQ-025 SHALL, in R1, send 0xFF and poll: 0xFF retries up to R1_TRIES; 0x00 -> TOKEN; other value or exhausted retries -> CS_HI with error=1.
REQ-026 SHALL, in TOKEN, send 0xFF and poll: 0xFF retries up to TOKEN_TRIES; 0xFE -> DATA; other value or exhausted retries -> CS_HI with error=2.
REQ-027 SHALL, in DATA, exchange 512 bytes of 0xFF; byte k asserts ram_we with ram_addr=dest+k (16-bit wrap) and ram_data=spi_din, in the cycle the byte becomes valid.
REQ-028 SHALL, in CRC, exchange 2 bytes of 0xFF and discard them.
REQ-029 SHALL always issue CS high (cmd 2) in CS_HI, including on error, then go to FIN.
REQ-030 SHALL, in FIN, pulse done for one cycle, drop busy, and return to IDLE; error holds until the next start.
REQ-031 SHALL abort any operation on spi_st[1]=1 observed with busy low, going to CS_HI with error=3.
REQ-032 SHALL keep the byte counter at 9 bits and the retry counter at 12 bits; neither SHALL wrap mid-phase.

Reset
REQ-033 SHALL, on reset, set state IDLE and busy, done, spi_sent, ram_we, error, spi_cmd and counters to 0, spi_out to 0xFF, ram_addr to 0, ram_data to 0.
REQ-034 SHALL, on reset mid-transfer, abandon the transfer without issuing CS high; the next start begins with CS_LO.

Structure
REQ-035 SHALL place SPI command codes (0/1/2), error codes, CMD17=0x51 and token 0xFE in a shared package sd_pkg.
REQ-036 SHALL place the byte-exchange handshake of REQ-022 in one sub-module, sd_xfer_byte; the FSM SHALL stay in sd_block_reader.

Verification
REQ-037 SHALL test: SDHC=1, lba=0x00000002, dest=0x8000, card model R1=0x00 after 2 0xFF polls, token after 3 polls, data i&0xFF -> CMD bytes 51 00 00 00 02 FF; 512 writes at 0x8000..0x81FF; done, error=0.
REQ-038 SHALL test: SDHC=0, lba=1 -> address bytes 00 00 02 00.
REQ-039 SHALL test: R1 always 0xFF -> exactly 16 polls, CS high issued, done, error=1.
REQ-040 SHALL test: token 0x05 -> no ram_we, error=2.
REQ-041 SHALL test: dest=0xFF00 -> writes wrap to 0x0000..0x00FF for the last 256 bytes.
REQ-042 SHALL test: spi_st[1] during DATA -> CS high, error=3; reset at byte 100 -> IDLE, busy=0, and the next start succeeds.
